// File: rtl/pc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pc_ctrl_unit
//
// Program-counter controller at the head of the fetch stage. On top of a
// plain loadable/incrementing PC it holds on stall, arbitrates redirects
// (exception > jump > branch), buffers a redirect that arrives while
// stalled, captures the exception PC, turns misaligned jump/branch targets
// into exceptions and pulses a fetch-bubble flag on every non-sequential
// PC change.
//
// Parameters:
//   WIDTH     PC/address width in bits
//   STEP      sequential increment in bytes (power of two)
//   RESET_VEC PC value at reset
//   EXC_VEC   exception handler address
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   stall_i     hold the PC and buffer any redirect
//   exc_en_i    take an exception this cycle
//   jump_en_i   jump redirect request, target jump_tgt_i
//   br_en_i     taken-branch redirect request, target br_tgt_i
//   pc_o        current fetch address
//   pc_seq_o    pc_o + STEP, combinational, wraps modulo 2^WIDTH
//   epc_o       exception PC
//   redirect_o  pc_o changed non-sequentially on the last edge
//   pending_o   a buffered redirect is waiting for stall release
//   align_err_o a misaligned jump/branch target was rejected on the last edge
// ---------------------------------------------------------------------------
module pc_ctrl_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h8000_0180)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             exc_en_i,
    input  logic             jump_en_i,
    input  logic [WIDTH-1:0] jump_tgt_i,
    input  logic             br_en_i,
    input  logic [WIDTH-1:0] br_tgt_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_seq_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             redirect_o,
    output logic             pending_o,
    output logic             align_err_o
);

    // Low address bits that must be zero for a legal fetch target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pendTgt_q, pendTgt_d;
    logic             pendExc_q, pendExc_d;
    logic             redirect_q, redirect_d;
    logic             alignErr_q, alignErr_d;

    logic [WIDTH-1:0] pcSeq;
    logic             jumpMis;
    logic             brMis;

    logic             reqValid;
    logic             reqIsExc;
    logic             reqMis;
    logic [WIDTH-1:0] reqTgt;
    logic [WIDTH-1:0] reqEpc;

    logic             winValid;
    logic             winIsExc;
    logic [WIDTH-1:0] winTgt;

    assign pcSeq   = pc_q + WIDTH'(STEP);
    assign jumpMis = |(jump_tgt_i & ALIGN_MASK);
    assign brMis   = |(br_tgt_i & ALIGN_MASK);

    // Resolve this cycle's requests into a single winner. A misaligned
    // jump/branch is turned into an exception whose EPC is the bad target;
    // a plain exception records the current PC instead.
    always_comb begin
        reqValid = exc_en_i | jump_en_i | br_en_i;
        reqTgt   = '0;
        reqIsExc = 1'b0;
        reqMis   = 1'b0;
        reqEpc   = pc_q;
        if (exc_en_i) begin
            reqTgt   = EXC_VEC;
            reqIsExc = 1'b1;
        end else if (jump_en_i) begin
            if (jumpMis) begin
                reqTgt   = EXC_VEC;
                reqIsExc = 1'b1;
                reqMis   = 1'b1;
                reqEpc   = jump_tgt_i;
            end else begin
                reqTgt = jump_tgt_i;
            end
        end else if (br_en_i) begin
            if (brMis) begin
                reqTgt   = EXC_VEC;
                reqIsExc = 1'b1;
                reqMis   = 1'b1;
                reqEpc   = br_tgt_i;
            end else begin
                reqTgt = br_tgt_i;
            end
        end
    end

    // Merge the new request with any buffered one. An exception always
    // wins; a buffered exception is never displaced by a jump/branch, but
    // a buffered jump/branch is replaced by a newer jump/branch.
    always_comb begin
        winValid = reqValid;
        winTgt   = reqTgt;
        winIsExc = reqIsExc;
        if (state_q == ST_HOLD) begin
            winValid = 1'b1;
            if (!reqValid || (!reqIsExc && pendExc_q)) begin
                winTgt   = pendTgt_q;
                winIsExc = pendExc_q;
            end
        end
    end

    // State register plus all datapath registers; reset discards any
    // buffered redirect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            pendTgt_q  <= '0;
            pendExc_q  <= 1'b0;
            redirect_q <= 1'b0;
            alignErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pendTgt_q  <= pendTgt_d;
            pendExc_q  <= pendExc_d;
            redirect_q <= redirect_d;
            alignErr_q <= alignErr_d;
        end
    end

    // Next-state logic: enter HOLD when a request lands during a stall,
    // leave it as soon as the stall drops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (stall_i && reqValid) state_d = ST_HOLD;
            ST_HOLD: if (!stall_i)            state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Datapath next values. EPC and the alignment flag follow the request
    // at the moment it arrives, stalled or not; the PC itself only moves
    // when the stall is low, and every such move to a winning target is
    // flagged as a redirect.
    always_comb begin
        pc_d       = pc_q;
        pendTgt_d  = pendTgt_q;
        pendExc_d  = pendExc_q;
        redirect_d = 1'b0;
        alignErr_d = reqValid && reqMis;
        epc_d      = (reqValid && reqIsExc) ? reqEpc : epc_q;
        if (stall_i) begin
            if (winValid) begin
                pendTgt_d = winTgt;
                pendExc_d = winIsExc;
            end
        end else begin
            pendTgt_d = '0;
            pendExc_d = 1'b0;
            if (winValid) begin
                pc_d       = winTgt;
                redirect_d = 1'b1;
            end else begin
                pc_d = pcSeq;
            end
        end
    end

    // Output logic.
    always_comb begin
        pending_o   = (state_q == ST_HOLD);
        pc_o        = pc_q;
        pc_seq_o    = pcSeq;
        epc_o       = epc_q;
        redirect_o  = redirect_q;
        align_err_o = alignErr_q;
    end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_ctrl_unit
//
// Directed bench for pc_ctrl_unit with the default parameters (32-bit PC,
// STEP 4, reset vector 0, exception vector 0x8000_0180). Inputs change one
// time unit after a rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_pc_ctrl_unit;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        excEn;
    logic        jumpEn;
    logic [31:0] jumpTgt;
    logic        brEn;
    logic [31:0] brTgt;
    logic [31:0] pc;
    logic [31:0] pcSeq;
    logic [31:0] epc;
    logic        redirect;
    logic        pending;
    logic        alignErr;

    int total = 0;
    int bad   = 0;

    pc_ctrl_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .exc_en_i   (excEn),
        .jump_en_i  (jumpEn),
        .jump_tgt_i (jumpTgt),
        .br_en_i    (brEn),
        .br_tgt_i   (brTgt),
        .pc_o       (pc),
        .pc_seq_o   (pcSeq),
        .epc_o      (epc),
        .redirect_o (redirect),
        .pending_o  (pending),
        .align_err_o(alignErr)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's request inputs.
    task automatic applyStimulus(input logic st, input logic ex, input logic jp, input logic [31:0] jt,
                                 input logic bp, input logic [31:0] bt);
        stall   = st;
        excEn   = ex;
        jumpEn  = jp;
        jumpTgt = jt;
        brEn    = bp;
        brTgt   = bt;
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #12;
        rst = 1'b0;

        // Reset state
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_pcseq", pcSeq, 32'h4);
        checkOutput("rst_epc", epc, 32'h0);
        checkOutput("rst_redirect", {31'b0, redirect}, 32'h0);
        checkOutput("rst_pending", {31'b0, pending}, 32'h0);
        checkOutput("rst_alignerr", {31'b0, alignErr}, 32'h0);

        // Free running
        tick();
        checkOutput("run_pc4", pc, 32'h4);
        checkOutput("run_seq8", pcSeq, 32'h8);
        tick();
        checkOutput("run_pc8", pc, 32'h8);
        tick();
        checkOutput("run_pcC", pc, 32'hC);
        checkOutput("run_seq10", pcSeq, 32'h10);
        checkOutput("run_redirect", {31'b0, redirect}, 32'h0);
        tick();
        checkOutput("run_pc10", pc, 32'h10);

        // Jump beats branch
        applyStimulus(0, 0, 1, 32'h400, 1, 32'h800);
        tick();
        checkOutput("jmp_pc", pc, 32'h400);
        checkOutput("jmp_redirect", {31'b0, redirect}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("jmp_next_pc", pc, 32'h404);
        checkOutput("jmp_redirect_off", {31'b0, redirect}, 32'h0);

        // Get to 0x20, then branch while stalled
        applyStimulus(0, 0, 1, 32'h20, 0, 0);
        tick();
        checkOutput("to20_pc", pc, 32'h20);
        applyStimulus(1, 0, 0, 0, 1, 32'h100);
        tick();
        checkOutput("stbr_pc", pc, 32'h20);
        checkOutput("stbr_pending", {31'b0, pending}, 32'h1);
        checkOutput("stbr_redirect", {31'b0, redirect}, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("stbr_hold_pc", pc, 32'h20);
        checkOutput("stbr_hold_pending", {31'b0, pending}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("stbr_rel_pc", pc, 32'h100);
        checkOutput("stbr_rel_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("stbr_rel_pending", {31'b0, pending}, 32'h0);

        // Stalled jump, then exception, then branch: exception wins
        applyStimulus(1, 0, 1, 32'h200, 0, 0);
        tick();
        checkOutput("stx_pc_a", pc, 32'h100);
        checkOutput("stx_epc_a", epc, 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        checkOutput("stx_epc_b", epc, 32'h100);
        checkOutput("stx_pending_b", {31'b0, pending}, 32'h1);
        applyStimulus(1, 0, 0, 0, 1, 32'h300);
        tick();
        checkOutput("stx_pc_c", pc, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("stx_rel_pc", pc, EXC);
        checkOutput("stx_rel_epc", epc, 32'h100);
        checkOutput("stx_rel_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("stx_rel_pending", {31'b0, pending}, 32'h0);

        // Misaligned jump at 0x40
        applyStimulus(0, 0, 1, 32'h40, 0, 0);
        tick();
        checkOutput("to40_pc", pc, 32'h40);
        applyStimulus(0, 0, 1, 32'h402, 0, 0);
        tick();
        checkOutput("mis_pc", pc, EXC);
        checkOutput("mis_epc", epc, 32'h402);
        checkOutput("mis_alignerr", {31'b0, alignErr}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("mis_next_pc", pc, 32'h8000_0184);
        checkOutput("mis_alignerr_off", {31'b0, alignErr}, 32'h0);

        // Exception beats jump; EPC is the current PC
        applyStimulus(0, 1, 1, 32'h500, 0, 0);
        tick();
        checkOutput("excpri_pc", pc, EXC);
        checkOutput("excpri_epc", epc, 32'h8000_0184);

        // Misaligned branch ignored when the jump wins
        applyStimulus(0, 0, 1, 32'h600, 1, 32'h601);
        tick();
        checkOutput("jmpmisbr_pc", pc, 32'h600);
        checkOutput("jmpmisbr_alignerr", {31'b0, alignErr}, 32'h0);
        checkOutput("jmpmisbr_epc", epc, 32'h8000_0184);

        // Buffered exception not displaced by a later jump
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick();
        checkOutput("pexc_epc", epc, 32'h600);
        applyStimulus(1, 0, 1, 32'h700, 0, 0);
        tick();
        checkOutput("pexc_pc", pc, 32'h600);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pexc_rel_pc", pc, EXC);

        // Buffered branch replaced by a jump arriving on the release cycle
        applyStimulus(1, 0, 0, 0, 1, 32'h900);
        tick();
        checkOutput("prep_pending", {31'b0, pending}, 32'h1);
        applyStimulus(0, 0, 1, 32'hA00, 0, 0);
        tick();
        checkOutput("prep_rel_pc", pc, 32'hA00);
        checkOutput("prep_rel_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("prep_rel_pending", {31'b0, pending}, 32'h0);

        // PC wrap
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        tick();
        checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
        checkOutput("wrap_seq", pcSeq, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("wrap_next_pc", pc, 32'h0);
        checkOutput("wrap_redirect", {31'b0, redirect}, 32'h0);
        tick();
        checkOutput("wrap_pc4", pc, 32'h4);

        // Asynchronous reset while in HOLD
        applyStimulus(1, 0, 1, 32'h300, 0, 0);
        tick();
        checkOutput("arst_pre_pending", {31'b0, pending}, 32'h1);
        checkOutput("arst_pre_pc", pc, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pc", pc, 32'h0);
        checkOutput("arst_pending", {31'b0, pending}, 32'h0);
        checkOutput("arst_epc", epc, 32'h0);
        #2;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("arst_after_pc", pc, 32'h4);
        checkOutput("arst_after_redirect", {31'b0, redirect}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_unit.md
Name: pc_ctrl_unit

Overview:
- Parametrised program-counter controller; next generation of the loadable/incrementing PC register.
- Sits at the head of the fetch stage.
- Adds the following over a plain loadable register:
  - stall hold,
  - prioritised redirects (exception / jump / branch),
  - buffering of a redirect that arrives while stalled,
  - exception PC capture (EPC),
  - misaligned-target detection,
  - a one-cycle fetch-bubble pulse on every non-sequential PC change.

Parameters:
- WIDTH, 32: PC/address width in bits.
- STEP, 4: sequential increment in bytes; must be a power of two.
- RESET_VEC, 32'h0000_0000: PC value at reset.
- EXC_VEC, 32'h8000_0180: exception handler address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; buffer any redirect.
- exc_en  in  1  take exception this cycle.
- jump_en  in  1  jump redirect request.
- jump_tgt  in  WIDTH  jump target.
- br_en  in  1  taken-branch redirect request.
- br_tgt  in  WIDTH  branch target.
- pc  out  WIDTH  current fetch address.
- pc_seq  out  WIDTH  pc+STEP; combinational, wraps modulo 2^WIDTH.
- epc  out  WIDTH  exception PC.
- redirect  out  1  pulse: pc changed non-sequentially on the last edge.
- pending  out  1  a buffered redirect is waiting for stall release.
- align_err  out  1  pulse: a misaligned jump/branch target was rejected.

Behaviour:
- Reset (asynchronous):
  - pc=RESET_VEC, epc=0, redirect=0, pending=0, align_err=0.
  - Pending target cleared; FSM=RUN.
- Alignment:
  - A target is misaligned if any of its low log2(STEP) bits are nonzero.
  - A misaligned jump/branch is converted to an exception: tgt→EXC_VEC, epc←offending target, align_err=1 for one cycle.
  - This conversion applies in both RUN and HOLD.
- Request priority within one cycle: exc_en > jump_en > br_en. Lower-priority requests are ignored.
- Exception EPC capture: epc←pc (value at that edge). The exception target is EXC_VEC.
- FSM has two states:
  - RUN: no buffered redirect.
  - HOLD: buffered target valid; pending=1.
- RUN, stall=0:
  - Request present: pc←winning target, redirect=1 next cycle.
  - No request: pc←pc+STEP (wraps at 2^WIDTH), redirect=0.
- RUN, stall=1:
  - pc holds.
  - Request present: store winning target plus an is_exc flag; go to HOLD.
  - epc updates at request time, not at release.
- HOLD, stall=1 (new request):
  - New exception overwrites any pending target.
  - New non-exception request overwrites a pending non-exception target only.
  - A pending exception is never displaced by jump/branch.
  - pc holds.
- HOLD, stall=0:
  - No new request: pc←pending target, redirect=1, go to RUN.
  - New request this cycle: the same override rule decides the target; pc←that target, redirect=1, go to RUN.
  - Pending is cleared in both cases.
- redirect is registered and high exactly one cycle after any non-sequential pc load. It never asserts during stall cycles.
- epc updates only on exception/misalignment and holds otherwise.
- Reset mid-HOLD discards the pending target immediately.
- Latency: redirect to pc is one clock when not stalled; stall release to pc=pending target is one clock.

Test Plan:
- Reset, then 3 free-running cycles → pc=0x0, 0x4, 0x8, 0xC; redirect=0; pc_seq=pc+4 each cycle.
- At pc=0x10 assert jump_en, jump_tgt=0x400 and br_en, br_tgt=0x800 together → pc=0x400 next cycle; redirect pulses for 1 cycle; next pc=0x404.
- stall=1 at pc=0x20; br_en with br_tgt=0x100 for one cycle; hold 3 cycles → pc stays 0x20, pending=1. Release stall → pc=0x100, redirect=1, pending=0.
- While stalled: jump to 0x200, then exc_en, then br_en to 0x300 on successive cycles → after release pc=0x80000180; epc=pc held during the stall.
- jump_en with jump_tgt=0x402 at pc=0x40 → pc=0x80000180, epc=0x402, align_err=1 for one cycle.
- PC wrap: jump to 0xFFFFFFFC, one free cycle → pc=0x0. Assert rst asynchronously in HOLD → pc=0, pending=0 without waiting for a clock edge.
